// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
// Owns the fetch PC and applies ID-resolved redirects, stalls, flushes and the syscall halt.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_taken,
    input  logic [15:0]        br_imm,
    input  logic               jmp,
    input  logic [25:0]        jmp_index,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    input  logic               halt,
    input  logic               resume,
    output logic [31:0]        pc,
    output logic [31:0]        ir_id,
    output logic [31:0]        pc_id,
    output logic [31:0]        pc4_id,
    output logic               valid_id,
    output logic               halted,
    output logic [31:0]        fetch_count,
    output logic               misalign_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_plus4;
    logic        redirect_req;
    logic        halt_take;
    logic        redirect_take;
    logic [31:0] redirect_pc;
    logic        jr_misaligned;

    function automatic logic [31:0] branch_target(input logic [31:0] link,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return link + $unsigned(offset);
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] link,
                                                input logic [25:0] index);
        return {link[31:28], index, 2'b00};
    endfunction

    function automatic logic [31:0] reg_target(input logic [31:0] rs_val);
        return {rs_val[31:2], 2'b00};
    endfunction

    assign imem_addr = pc[IMEM_AW+1:2];
    assign halted    = (state == HALT);
    assign pc_plus4  = pc + 32'd4;

    // Redirect decode: jr beats j/jal, which beats a taken branch
    always_comb begin
        redirect_pc = branch_target(pc4_id, br_imm);
        if (jr) begin
            redirect_pc = reg_target(jr_target);
        end else if (jmp) begin
            redirect_pc = jump_target(pc4_id, jmp_index);
        end
    end

    assign redirect_req  = jr | jmp | br_taken;
    assign halt_take     = (state == RUN) & halt & valid_id & ~stall;
    assign redirect_take = (state == RUN) & ~halt_take & ~stall & valid_id & redirect_req;
    assign jr_misaligned = jr & (jr_target[1:0] != 2'b00);

    // PC and IF/ID register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            pc           <= RESET_PC;
            ir_id        <= 32'd0;
            pc_id        <= 32'd0;
            pc4_id       <= 32'd0;
            valid_id     <= 1'b0;
            fetch_count  <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_take) begin
                        ir_id    <= 32'd0;
                        valid_id <= 1'b0;
                        state    <= HALT;
                    end else if (stall) begin
                        state <= RUN;
                    end else if (redirect_take) begin
                        pc       <= redirect_pc;
                        ir_id    <= 32'd0;
                        valid_id <= 1'b0;
                        if (jr_misaligned) begin
                            misalign_err <= 1'b1;
                        end
                    end else if (flush) begin
                        pc       <= pc_plus4;
                        ir_id    <= 32'd0;
                        valid_id <= 1'b0;
                    end else begin
                        pc          <= pc_plus4;
                        ir_id       <= imem_rdata;
                        pc_id       <= pc;
                        pc4_id      <= pc_plus4;
                        valid_id    <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                HALT: begin
                    // The held pc is already syscall+4, so resuming just restarts fetch there
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
- Holds the PC, drives the instruction-memory address, and latches the fetched word into the IF/ID register; ir_id feeds the decoder directly.
- Applies PC redirects resolved in ID (branch, j/jal, jr), stalls, flushes and the syscall halt.
- No branch delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and fetched first.
IMEM_AW, 10, word-address width presented to instruction memory.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_addr  out  IMEM_AW  word address, equals pc[IMEM_AW+1:2]; combinational read
imem_rdata  in  32  instruction word for imem_addr, valid in the same cycle
stall  in  1  hazard hold: PC and IF/ID keep their values
flush  in  1  load a bubble into IF/ID
br_taken  in  1  branch in ID is taken
br_imm  in  16  branch offset field of the instruction in ID
jmp  in  1  j/jal in ID
jmp_index  in  26  target field of j/jal in ID
jr  in  1  jr in ID
jr_target  in  32  rs value for jr
halt  in  1  syscall decoded in ID
resume  in  1  single-cycle pulse that leaves the halted state
pc  out  32  current fetch PC
ir_id  out  32  IF/ID instruction word
pc_id  out  32  IF/ID PC
pc4_id  out  32  IF/ID PC+4, used as the jal link value
valid_id  out  1  IF/ID holds a real instruction
halted  out  1  state == HALT
fetch_count  out  32  number of instructions loaded into IF/ID
misalign_err  out  1  sticky flag: jr_target[1:0] != 0 was seen

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc=RESET_PC; ir_id=0; pc_id=0; pc4_id=0; valid_id=0.
  - state=RUN; fetch_count=0; misalign_err=0.
  - Reset mid-operation aborts any redirect or halt in progress.
- Redirect targets, 32-bit arithmetic with wrap:
  - branch: pc4_id + {{14{br_imm[15]}}, br_imm, 2'b00}
  - jump: {pc4_id[31:28], jmp_index, 2'b00}
  - jr: {jr_target[31:2], 2'b00}
- Redirect priority: jr > jmp > br_taken. Redirects are honoured only when valid_id=1, stall=0 and state=RUN.
- State RUN, per rising edge, first matching rule applies:
  1. halt & valid_id & !stall: pc holds; IF/ID loads a bubble; state becomes HALT.
  2. stall: pc and all IF/ID registers hold. flush is ignored. No count.
  3. Redirect honoured: pc <= target; IF/ID loads a bubble, squashing the wrong-path fetch.
  4. flush: pc <= pc+4; IF/ID loads a bubble.
  5. Otherwise: pc <= pc+4; ir_id <= imem_rdata; pc_id <= pc; pc4_id <= pc+4; valid_id <= 1; fetch_count increments.
- Bubble: ir_id=0 (a nop), valid_id=0, pc_id and pc4_id hold.
- State HALT:
  - pc holds; IF/ID holds the bubble; all other inputs except resume are ignored.
  - resume: state becomes RUN. The next fetch is the held pc, i.e. the syscall address + 4.
- fetch_count increments only in rule 5 and wraps from 32'hFFFF_FFFF to 0.
- misalign_err sets on an honoured jr with jr_target[1:0] != 0 and clears only on reset.
- All outputs are registered except imem_addr and halted, which decode pc and state combinationally.

Test Plan:
- Reset then 3 free-running cycles with imem returning 32'h2008_0005, 32'h2009_0003, 32'h0109_5020 → pc=0x4, 0x8, 0xC; ir_id follows one cycle behind; valid_id=1; fetch_count=3.
- Instruction at pc_id=0x10 has br_taken=1, br_imm=16'hFFFC → pc=0x4; next ir_id=0 with valid_id=0; fetch_count unchanged for that cycle.
- Same cycle: jr=1 with jr_target=0x0000_0042, jmp=1 and br_taken=1 → pc=0x40; misalign_err=1 and stays set until rst_n low.
- stall held 2 cycles together with br_taken=1 and flush=1 → pc, ir_id and fetch_count frozen; branch and flush ignored. Release stall with br_taken still 1 → redirect taken.
- halt with valid_id=1 at pc=0x24 → halted=1 and pc stays 0x24 for 5 cycles; resume pulse → the next edge loads ir_id from 0x24, pc=0x28.
- Preload fetch_count=32'hFFFF_FFFF via force, then one fetch → 0. Assert rst_n low mid-halt → pc=RESET_PC and halted=0 immediately, without waiting for a clock edge.
